// File: rtl/timer_disp_pkg.sv
// Shared definitions for the countdown display scanner: segment codes,
// anode patterns and the digit-slot index type.
package timer_disp_pkg;

  // Segment codes are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SLOT_UNITS = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_MINS  = 2'd2,
    SLOT_BLANK = 2'd3
  } slot_idx_t;

  // One anode low per slot; slot 0 drives the rightmost digit.
  function automatic logic [3:0] slot_anode(input slot_idx_t slot);
    logic [3:0] onehot;
    onehot = 4'b0001 << slot;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; 10..15 show a dash.
module seg7_decode
  import timer_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/timer_display_scan.sv
// Multiplexed M.SS countdown display scanner with frame-locked digit capture.
// Optional blink-on-expiry is built only when TIMER_BLINK_EN is defined.
module timer_display_scan
  import timer_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       time_up
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  slot_idx_t     r_idx;
  logic [3:0]    r_a, r_b, r_c;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_time_up;
  logic          w_tick;
  logic          w_blink_mask;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digits are sampled only at the frame boundary so a frame never mixes old and new values.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= SLOT_UNITS;
      // NOTE: frame registers reset to F, not 0, so time_up cannot fire before the first capture.
      r_a   <= 4'hF;
      r_b   <= 4'hF;
      r_c   <= 4'hF;
    end else if (w_tick) begin
      r_idx <= slot_idx_t'(r_idx + 2'd1);
      if (r_idx == SLOT_BLANK) begin
        r_a <= A;
        r_b <= B;
        r_c <= C;
      end
    end
  end

  always_comb begin
    w_digit = r_c;
    case (r_idx)
      SLOT_UNITS: w_digit = r_c;
      SLOT_TENS:  w_digit = r_b;
      SLOT_MINS:  w_digit = r_a;
      default:    w_digit = r_c;
    endcase
  end

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_time_up <= 1'b0;
    end else begin
      r_time_up <= (r_a == 4'd0) && (r_b == 4'd0) && (r_c == 4'd0);
    end
  end

`ifdef TIMER_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (!r_time_up) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_blink_mask = r_phase;
`else
  assign w_blink_mask = 1'b0;
`endif

  // Drive pins from flops; they follow the slot index one cycle later.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= AN_OFF;
    end else begin
      r_an  <= (enable && !w_blink_mask) ? slot_anode(r_idx) : AN_OFF;
      r_seg <= (!enable || (r_idx == SLOT_BLANK)) ? SEG_BLANK : w_seg_dec;
      r_dp  <= !(enable && (r_idx == SLOT_MINS));
    end
  end

  assign seg     = r_seg;
  assign dp      = r_dp;
  assign an      = r_an;
  assign time_up = r_time_up;

endmodule

// File: tb/tb_timer_display_scan.sv
// Self-checking bench for timer_display_scan (SCAN_DIV=4, BLINK_DIV=2) against a cycle-count model.
module tb_timer_display_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = SCAN_DIV * 4;
`ifdef TIMER_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic [3:0] A, B, C;
  logic       enable;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       time_up;

  int total = 0;
  int bad   = 0;

  timer_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .C       (C),
    .enable  (enable),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .time_up (time_up)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: everything derives from the number of clock edges since reset release.
  int         m_n;
  int         m_tu_ticks;
  int         m_slot;
  logic [3:0] m_fa, m_fb, m_fc, m_digit;
  logic       m_tu, m_new_tu, m_phase;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [3:0] m_an;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      m_n = 0; m_tu_ticks = 0;
      m_fa = 4'hF; m_fb = 4'hF; m_fc = 4'hF;
      m_tu = 1'b0;
      m_seg = 7'h7F; m_dp = 1'b1; m_an = 4'hF;
    end else begin
      m_slot  = (m_n / SCAN_DIV) % 4;
      m_phase = BLINK_ON && (((m_tu_ticks / BLINK_DIV) % 2) == 1);
      m_digit = (m_slot == 0) ? m_fc : (m_slot == 1) ? m_fb : m_fa;
      m_an    = (!enable || m_phase) ? 4'hF : (4'hF ^ (4'b0001 << m_slot));
      m_seg   = (!enable || m_slot == 3) ? 7'h7F : seg_of(m_digit);
      m_dp    = !(enable && m_slot == 2);
      m_new_tu = (m_fa == 0) && (m_fb == 0) && (m_fc == 0);
      if (!m_tu) m_tu_ticks = 0;
      else if (((m_n + 1) % SCAN_DIV) == 0) m_tu_ticks++;
      m_tu = m_new_tu;
      if (((m_n + 1) % FRAME) == 0) begin
        m_fa = A; m_fb = B; m_fc = C;
      end
      m_n++;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("seg",     {1'b0, seg},      {1'b0, m_seg});
    check("an",      {4'b0, an},       {4'b0, m_an});
    check("dp",      {7'b0, dp},       {7'b0, m_dp});
    check("time_up", {7'b0, time_up},  {7'b0, m_tu});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an"},  {4'b0, an},      8'h0F);
    check({tag, "_seg"}, {1'b0, seg},     8'h7F);
    check({tag, "_dp"},  {7'b0, dp},      8'h01);
    check({tag, "_tu"},  {7'b0, time_up}, 8'h00);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(negedge clk_in);
      check_outputs();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    A = 4'd0; B = 4'd0; C = 4'd0;
    enable = 1'b1;
    @(negedge clk_in);
    check_reset_state("por");
    #2 reset_n = 1'b1;

    // Digits 2:37, then change C mid-frame.
    A = 4'd2; B = 4'd3; C = 4'd7;
    run(40);
    run(6);
    C = 4'd5;
    run(30);

    // Out-of-range digit and enable gating.
    B = 4'd12;
    run(20);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(20);

    // Expiry, then recovery.
    A = 4'd0; B = 4'd0; C = 4'd0;
    run(60);
    check("tu_high", {7'b0, time_up}, 8'h01);
    C = 4'd1;
    run(40);
    check("tu_low", {7'b0, time_up}, 8'h00);

    // Mid-scan reset while time_up is high, checked before any clock edge.
    C = 4'd0;
    run(37);
    check("tu_before_rst", {7'b0, time_up}, 8'h01);
    #2 reset_n = 1'b0;
    #1 check_reset_state("rst_async");
    run(2);
    check_reset_state("rst_hold");
    #2 reset_n = 1'b1;
    run(40);

    // Randomized digits and enable toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(2) == 0) begin
          A = 4'd0; B = 4'd0; C = 4'd0;
        end else begin
          A = 4'($urandom_range(15));
          B = 4'($urandom_range(15));
          C = 4'($urandom_range(15));
        end
      end
      if ($urandom_range(15) == 0) enable = ~enable;
      run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
